sync_packetizer: RTL and testbench

Consumer of the packet synchronization signal produced by the level-triggered sync generator. Takes the ADC16DV160 input stream (two 16-bit samples per 32-bit word) and the `sync` level. Frames every `sync`-high interval into AXI-Stream packets, marking `tlast` on the final word. Sits between the ADC input path and the DMA, buffering through an internal FIFO with backpressure and overflow accounting.

---
 rtl/sync_packetizer_pkg.sv | 33 +++
 rtl/sync_fifo.sv | 96 +++++++++
 rtl/sync_packetizer.sv | 195 +++++++++++++++++++
 tb/tb_sync_packetizer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_packetizer_pkg.sv
// sync_packetizer_pkg: shared types and constants for the sync-framed
// AXI-Stream packetizer (state encoding, FIFO word layout, header magic).
package sync_packetizer_pkg;

  // Framing FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2,
    DROP   = 2'd3
  } state_t;

  // One FIFO entry: data word plus end-of-packet marker
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_word_t;

  // Upper half of the optional packet header word
  localparam logic [15:0] HEADER_MAGIC = 16'hA5A5;

  // Saturating 32-bit increment used for the overflow counter
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO of fifo_word_t.
// Storage is a circular buffer that keeps one slot in reserve, so it holds
// FIFO_DEPTH-1 words. The head word is registered into rd_word one cycle
// after it lands in storage and stays in its storage slot until popped, so
// `free` counts every word not yet consumed. `free` ignores the pop of the
// current cycle (conservative for the writer).
module sync_fifo
  import sync_packetizer_pkg::*;
#(
  parameter int FIFO_DEPTH = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  fifo_word_t                    wr_word,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output fifo_word_t                    rd_word,
  output logic [$clog2(FIFO_DEPTH):0]   free,
  output logic                          empty,
  output logic                          full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CAPACITY = (AW+1)'(FIFO_DEPTH - 1);

  fifo_word_t    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_next_s;
  logic [AW:0]   count_r;
  logic [AW:0]   stored_after_pop_s;
  logic          rd_valid_r;
  fifo_word_t    rd_word_r;
  logic          push_s;
  logic          pop_s;

  assign full     = (count_r == CAPACITY);
  assign empty    = (count_r == (AW+1)'(0));
  assign free     = CAPACITY - count_r;
  assign push_s   = wr_en && !full;
  assign pop_s    = rd_valid_r && rd_ready;
  assign rd_valid = rd_valid_r;
  assign rd_word  = rd_word_r;

  // Read pointer and stored-word count as they will be after this cycle's pop
  always_comb begin
    rd_next_s          = rd_ptr_r;
    stored_after_pop_s = count_r;
    if (pop_s) begin
      rd_next_s          = rd_ptr_r + AW'(1);
      stored_after_pop_s = count_r - (AW+1)'(1);
    end else begin
      rd_next_s          = rd_ptr_r;
      stored_after_pop_s = count_r;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_word;
    end
  end

  // Pointers, occupancy and the registered head-of-queue presentation
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= AW'(0);
      rd_ptr_r   <= AW'(0);
      count_r    <= (AW+1)'(0);
      rd_valid_r <= 1'b0;
      rd_word_r  <= '{last: 1'b0, data: 32'd0};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_next_s;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      // Only words already in storage before this edge may be presented;
      // the head slot cannot be overwritten while it is occupied.
      if (stored_after_pop_s != (AW+1)'(0)) begin
        rd_valid_r <= 1'b1;
        rd_word_r  <= mem_r[rd_next_s];
      end else begin
        rd_valid_r <= 1'b0;
        rd_word_r  <= rd_word_r;
      end
    end
  end

endmodule

// File: rtl/sync_packetizer.sv
// sync_packetizer: frames every sync-high interval of the ADC word stream
// into AXI-Stream packets with tlast on the final word. Each word is held
// for one capture so tlast can be attached when sync falls or the packet
// reaches max_pkt_words. Output is buffered in sync_fifo; words that do not
// fit are dropped and counted.
// Optional feature macro: SYNC_PACKETIZER_HEADER_EN -- prefixes every packet
// with {HEADER_MAGIC, seq[15:0]} and raises the start requirement to 3 free
// slots.
module sync_packetizer
  import sync_packetizer_pkg::*;
#(
  parameter int FIFO_DEPTH = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adc_data,
  input  logic        adc_data_valid,
  input  logic        sync,
  input  logic [15:0] max_pkt_words,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] pkt_count,
  output logic [31:0] overflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef SYNC_PACKETIZER_HEADER_EN
  localparam logic [AW:0] START_FREE = (AW+1)'(3);
`else
  localparam logic [AW:0] START_FREE = (AW+1)'(2);
`endif
  localparam logic [AW:0] HOLD_FREE = (AW+1)'(2);

  state_t      state_r;
  logic [31:0] hold_r;
  logic [15:0] max_r;
  logic [15:0] n_r;
  logic [31:0] pkt_count_r;
  logic [31:0] overflow_count_r;
`ifdef SYNC_PACKETIZER_HEADER_EN
  logic [15:0] seq_r;
`endif

  logic        capture_s;
  logic        start_ok_s;
  logic        wr_en_s;
  fifo_word_t  wr_word_s;
  fifo_word_t  rd_word_s;
  logic        rd_valid_s;
  logic [AW:0] free_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        unused_s;

  assign capture_s  = adc_data_valid && sync;
  assign start_ok_s = (free_s >= START_FREE);
  assign unused_s   = ^{fifo_empty_s, fifo_full_s};

  // FIFO write selection: header at packet start, held word on close/advance
  always_comb begin
    wr_en_s   = 1'b0;
    wr_word_s = '{last: 1'b0, data: 32'd0};
    case (state_r)
      IDLE: begin
`ifdef SYNC_PACKETIZER_HEADER_EN
        if (capture_s && start_ok_s) begin
          wr_en_s   = 1'b1;
          wr_word_s = '{last: 1'b0, data: {HEADER_MAGIC, seq_r}};
        end else begin
          wr_en_s   = 1'b0;
        end
`else
        wr_en_s = 1'b0;
`endif
      end
      ACTIVE: begin
        if (!sync) begin
          wr_en_s   = 1'b1;
          wr_word_s = '{last: 1'b1, data: hold_r};
        end else if (capture_s) begin
          // With only one slot left the held word closes the packet
          wr_en_s   = 1'b1;
          wr_word_s = '{last: (free_s < HOLD_FREE), data: hold_r};
        end else begin
          wr_en_s   = 1'b0;
        end
      end
      FLUSH: begin
        wr_en_s   = 1'b1;
        wr_word_s = '{last: 1'b1, data: hold_r};
      end
      DROP: begin
        wr_en_s = 1'b0;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Framing FSM with hold register, packet length tracking and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      hold_r           <= 32'd0;
      max_r            <= 16'd0;
      n_r              <= 16'd0;
      pkt_count_r      <= 32'd0;
      overflow_count_r <= 32'd0;
`ifdef SYNC_PACKETIZER_HEADER_EN
      seq_r            <= 16'd0;
`endif
    end else begin
      if (wr_en_s && wr_word_s.last) begin
        pkt_count_r <= pkt_count_r + 32'd1;
      end
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            if (start_ok_s) begin
              hold_r <= adc_data;
              max_r  <= max_pkt_words;
              n_r    <= 16'd1;
`ifdef SYNC_PACKETIZER_HEADER_EN
              seq_r  <= seq_r + 16'd1;
`endif
              // A limit of 0 or 1 makes every word its own packet
              if (max_pkt_words <= 16'd1) begin
                state_r <= FLUSH;
              end else begin
                state_r <= ACTIVE;
              end
            end else begin
              overflow_count_r <= sat_inc32(overflow_count_r);
              state_r          <= DROP;
            end
          end
        end
        ACTIVE: begin
          if (!sync) begin
            state_r <= IDLE;
          end else if (capture_s) begin
            if (free_s >= HOLD_FREE) begin
              hold_r <= adc_data;
              n_r    <= n_r + 16'd1;
              if ((n_r + 16'd1) == max_r) begin
                state_r <= FLUSH;
              end
            end else begin
              overflow_count_r <= sat_inc32(overflow_count_r);
              state_r          <= DROP;
            end
          end
        end
        FLUSH: begin
          state_r <= IDLE;
        end
        DROP: begin
          if (!sync) begin
            state_r <= IDLE;
          end else if (capture_s) begin
            overflow_count_r <= sat_inc32(overflow_count_r);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en_s),
    .wr_word  (wr_word_s),
    .rd_ready (m_axis_tready),
    .rd_valid (rd_valid_s),
    .rd_word  (rd_word_s),
    .free     (free_s),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s)
  );

  assign m_axis_tvalid  = rd_valid_s;
  assign m_axis_tdata   = rd_word_s.data;
  assign m_axis_tlast   = rd_word_s.last;
  assign pkt_count      = pkt_count_r;
  assign overflow_count = overflow_count_r;

endmodule

// File: tb/tb_sync_packetizer.sv
// tb_sync_packetizer: table-driven checks of packet framing (length limits,
// sync fall, valid/sync coincidence) plus hand-written overflow and
// mid-packet reset sequences. Uses FIFO_DEPTH = 8.
module tb_sync_packetizer;

  localparam int DEPTH = 8;
`ifdef SYNC_PACKETIZER_HEADER_EN
  localparam bit HDR       = 1'b1;
  localparam int OVF_WORDS = 6;
  localparam int OVF_DROPS = 6;
`else
  localparam bit HDR       = 1'b0;
  localparam int OVF_WORDS = 7;
  localparam int OVF_DROPS = 5;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adc_data;
  logic        adc_data_valid;
  logic        sync;
  logic [15:0] max_pkt_words;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [31:0] pkt_count;
  logic [31:0] overflow_count;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [32:0] got_q [$];
  logic [32:0] exp_q [$];
  int unsigned exp_pkt = 0;
  logic [15:0] exp_seq = 16'd0;

  typedef struct {
    int unsigned n_caps;
    logic [15:0] max_words;
    bit          fall_with_valid;
    int unsigned n_pkts;
    int unsigned sizes [4];
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  sync_packetizer #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .adc_data       (adc_data),
    .adc_data_valid (adc_data_valid),
    .sync           (sync),
    .max_pkt_words  (max_pkt_words),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .pkt_count      (pkt_count),
    .overflow_count (overflow_count)
  );

  // Record every accepted beat; inputs only change just after posedge
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back({m_axis_tlast, m_axis_tdata});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] dw(input int s, input int i);
    return {8'hD0, s[7:0], i[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [31:0] d);
    adc_data       = d;
    adc_data_valid = 1'b1;
    step();
    adc_data_valid = 1'b0;
    step();
  endtask

  task automatic add_pkt(input int s, input int first, input int n);
    if (HDR) begin
      exp_q.push_back({1'b0, 16'hA5A5, exp_seq});
      exp_seq = exp_seq + 16'd1;
    end
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({(k == n - 1), dw(s, first + k)});
    end
  endtask

  task automatic compare_stream(input string name);
    int n;
    check({name, " beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s beat%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int first;

    // n_caps, max, fall_with_valid, n_pkts, packet sizes
    vecs[0] = '{5,  16'd100, 1'b0, 1, '{5, 0, 0, 0}};
    vecs[1] = '{10, 16'd4,   1'b0, 3, '{4, 4, 2, 0}};
    vecs[2] = '{3,  16'd100, 1'b1, 1, '{3, 0, 0, 0}};
    vecs[3] = '{3,  16'd0,   1'b0, 3, '{1, 1, 1, 0}};
    vecs[4] = '{2,  16'd1,   1'b0, 2, '{1, 1, 0, 0}};
    vecs[5] = '{6,  16'd3,   1'b0, 2, '{3, 3, 0, 0}};

    reset          = 1'b1;
    adc_data       = 32'd0;
    adc_data_valid = 1'b0;
    sync           = 1'b0;
    max_pkt_words  = 16'd100;
    m_axis_tready  = 1'b1;
    repeat (3) step();
    check("reset tvalid", 64'(m_axis_tvalid), 64'd0);
    check("reset tlast", 64'(m_axis_tlast), 64'd0);
    check("reset tdata", 64'(m_axis_tdata), 64'd0);
    check("reset pkt_count", 64'(pkt_count), 64'd0);
    check("reset overflow_count", 64'(overflow_count), 64'd0);
    reset = 1'b0;
    step();

    // Table-driven framing scenarios with tready held high
    for (int v = 0; v < 6; v++) begin
      max_pkt_words = vecs[v].max_words;
      sync          = 1'b1;
      for (int i = 1; i <= int'(vecs[v].n_caps); i++) begin
        capture(dw(v, i));
      end
      if (vecs[v].fall_with_valid) begin
        adc_data       = 32'hDEAD_BEEF;
        adc_data_valid = 1'b1;
        sync           = 1'b0;
        step();
        adc_data_valid = 1'b0;
        step();
      end else begin
        sync = 1'b0;
        step();
      end
      repeat (16) step();
      first = 1;
      for (int p = 0; p < int'(vecs[v].n_pkts); p++) begin
        add_pkt(v, first, int'(vecs[v].sizes[p]));
        first += int'(vecs[v].sizes[p]);
      end
      exp_pkt += vecs[v].n_pkts;
      compare_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d pkt_count", v), 64'(pkt_count), 64'(exp_pkt));
      check($sformatf("vec%0d overflow_count", v), 64'(overflow_count), 64'd0);
    end

    // Overflow: tready low, 12 captures into a 7-word FIFO
    m_axis_tready = 1'b0;
    max_pkt_words = 16'd100;
    sync          = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      capture(dw(9, i));
    end
    sync = 1'b0;
    repeat (2) step();
    add_pkt(9, 1, OVF_WORDS);
    exp_pkt += 1;
    check("ovf overflow_count", 64'(overflow_count), 64'(OVF_DROPS));
    check("ovf pkt_count", 64'(pkt_count), 64'(exp_pkt));
    check("ovf tvalid", 64'(m_axis_tvalid), 64'd1);
    check("ovf head stable a", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q[0]));
    repeat (3) step();
    check("ovf head stable b", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_q[0]));
    m_axis_tready = 1'b1;
    repeat (16) step();
    compare_stream("ovf drain");
    check("ovf tvalid after drain", 64'(m_axis_tvalid), 64'd0);

    // Reset in the middle of a packet
    m_axis_tready = 1'b0;
    sync          = 1'b1;
    capture(dw(10, 1));
    capture(dw(10, 2));
    check("pre-reset tvalid", 64'(m_axis_tvalid), 64'd1);
    reset = 1'b1;
    sync  = 1'b0;
    step();
    check("midrst tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst tdata", 64'(m_axis_tdata), 64'd0);
    check("midrst pkt_count", 64'(pkt_count), 64'd0);
    check("midrst overflow_count", 64'(overflow_count), 64'd0);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_seq = 16'd0;
    step();

    // Clean traffic after reset: two 2-word packets
    m_axis_tready = 1'b1;
    max_pkt_words = 16'd2;
    sync          = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      capture(dw(11, i));
    end
    sync = 1'b0;
    repeat (16) step();
    add_pkt(11, 1, 2);
    add_pkt(11, 3, 2);
    exp_pkt += 2;
    compare_stream("post-reset");
    check("post-reset pkt_count", 64'(pkt_count), 64'(exp_pkt));
    check("post-reset overflow_count", 64'(overflow_count), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
